// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side blocks.
//   UART_DATA_W             : transmitter byte width
//   DEFAULT_TIMEOUT_CYCLES  : default per-frame watchdog limit for the arbiter
//   arb_state_t             : arbiter state encoding (ARB_IDLE, ARB_LAUNCH,
//                             ARB_WAIT_DONE, ARB_WAIT_CLEAR)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_LAUNCH     = 2'd1,
        ARB_WAIT_DONE  = 2'd2,
        ARB_WAIT_CLEAR = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side and transmitter-side signals of uart_tx_arbiter.
//   req_valid/req_data       : byte producers -> arbiter
//   req_ready/req_done       : arbiter -> producers, one-cycle pulses
//   grant_id                 : current or last granted requester
//   tx_start/tx_data         : arbiter -> transmitter
//   tx_busy/tx_done          : transmitter -> arbiter
//   arb_busy/timeout_err     : arbiter status
// Modports:
//   master : the arbiter itself
//   slave  : the surrounding producers and transmitter
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_done;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       tx_start;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_busy;
    logic                       tx_done;
    logic                       arb_busy;
    logic                       timeout_err;

    modport master (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, req_done, grant_id, tx_start, tx_data, arb_busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, req_done, grant_id, tx_start, tx_data, arb_busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: starting at rr_ptr and wrapping modulo
// NUM_REQ, returns the index of the first set bit of req_valid.
//   req_valid : request vector
//   rr_ptr    : highest-priority index for this search
//   winner    : index of the selected requester (0 when none valid)
//   any_valid : at least one request is set
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);
    localparam int PTR_W = $clog2(NUM_REQ);

    // Scan from the furthest offset back toward rr_ptr so the nearest hit
    // is the one that sticks; avoids an early-exit loop.
    always_comb begin
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (req_valid[idx]) begin
                winner    = PTR_W'(idx);
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers with round-robin
// arbitration. A byte is accepted with a one-cycle req_ready pulse, launched
// with tx_start (held until tx_busy), and completion is reported with a
// one-cycle req_done pulse once the transmitter is idle again.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_arbiter_if.master (requester and transmitter signals)
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a per-frame
// watchdog of TIMEOUT_CYCLES cycles; without it timeout_err is tied 0.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arbiter_if.master   bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]   grant_id_q, grant_id_nxt;
    logic [DATA_W-1:0]  tx_data_q, tx_data_nxt;
    logic               tx_start_q, tx_start_nxt;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_nxt;
    logic [NUM_REQ-1:0] req_done_q, req_done_nxt;
    logic [PTR_W-1:0]   winner;
    logic               any_valid;
    logic               timeout_hit;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] frame_cnt;
    logic             timeout_err_q;

    // Counter sits at 0 while idle, so it is cleared on every LAUNCH entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            frame_cnt     <= (state_nxt == ARB_IDLE) ? '0 : frame_cnt + CNT_W'(1);
            timeout_err_q <= timeout_hit;
        end
    end

    assign timeout_hit     = (state != ARB_IDLE) && (frame_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = timeout_err_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            grant_id_q  <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            req_done_q  <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            grant_id_q  <= grant_id_nxt;
            tx_data_q   <= tx_data_nxt;
            tx_start_q  <= tx_start_nxt;
            req_ready_q <= req_ready_nxt;
            req_done_q  <= req_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_id_nxt  = grant_id_q;
        tx_data_nxt   = tx_data_q;
        tx_start_nxt  = tx_start_q;
        req_ready_nxt = '0;
        req_done_nxt  = '0;

        case (state)
            ARB_IDLE: begin
                if (any_valid) begin
                    grant_id_nxt          = winner;
                    tx_data_nxt           = bus.req_data[winner*DATA_W +: DATA_W];
                    req_ready_nxt[winner] = 1'b1;
                    tx_start_nxt          = 1'b1;
                    rr_ptr_nxt            = (winner == PTR_W'(NUM_REQ - 1)) ? '0
                                                                            : winner + PTR_W'(1);
                    state_nxt             = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                // Busy wins even if tx_done is also high this cycle.
                if (bus.tx_busy) begin
                    tx_start_nxt = 1'b0;
                    state_nxt    = ARB_WAIT_DONE;
                end
            end
            ARB_WAIT_DONE: begin
                if (bus.tx_done) begin
                    state_nxt = ARB_WAIT_CLEAR;
                end
            end
            ARB_WAIT_CLEAR: begin
                if (!bus.tx_done && !bus.tx_busy) begin
                    req_done_nxt[grant_id_q] = 1'b1;
                    state_nxt                = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase

        // Watchdog abort overrides whatever the state wanted to do.
        if (timeout_hit) begin
            tx_start_nxt             = 1'b0;
            req_done_nxt             = '0;
            req_done_nxt[grant_id_q] = 1'b1;
            state_nxt                = ARB_IDLE;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.req_done  = req_done_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.arb_busy  = (state != ARB_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed testbench for uart_tx_arbiter with a small behavioural UART
// transmitter model and a negedge monitor that logs grants and completions.
// Build with UART_TX_ARB_TIMEOUT_EN defined to also exercise the watchdog
// (TIMEOUT_CYCLES = 64).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 4096;
`endif
    localparam int FRAME = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- transmitter model ----------------
    bit model_en  = 1'b1;
    int start_lat = 0;
    int tx_cnt    = 0;
    int wait_cnt  = 0;

    initial begin
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !model_en) begin
                tx_cnt = 0; wait_cnt = 0;
                bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
            end else begin
                if (tx_cnt == 0 && bus.tx_start) begin
                    if (wait_cnt >= start_lat) begin
                        tx_cnt = FRAME; wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
                if (tx_cnt > 0) begin
                    bus.tx_busy = 1'b1;
                    bus.tx_done = (tx_cnt <= 2);
                    tx_cnt--;
                end else begin
                    bus.tx_busy = 1'b0;
                    bus.tx_done = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    int g_id[$], g_data[$], g_cyc[$];
    int d_id[$], d_cyc[$], d_data[$], d_err[$], d_start[$], d_arb[$], d_txb[$], d_txd[$];
    int ready_twice = 0, done_twice = 0, err_seen = 0;
    logic [NUM_REQ-1:0] prev_ready = '0, prev_done = '0;

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = (r == -1) ? i : 99;
        return r;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != '0) begin
                g_id.push_back(oh_idx(bus.req_ready));
                g_data.push_back(int'(bus.tx_data));
                g_cyc.push_back(cyc);
                if (prev_ready != '0) ready_twice++;
            end
            if (bus.req_done != '0) begin
                d_id.push_back(oh_idx(bus.req_done));
                d_cyc.push_back(cyc);
                d_data.push_back(int'(bus.tx_data));
                d_err.push_back(int'(bus.timeout_err));
                d_start.push_back(int'(bus.tx_start));
                d_arb.push_back(int'(bus.arb_busy));
                d_txb.push_back(int'(bus.tx_busy));
                d_txd.push_back(int'(bus.tx_done));
                if (prev_done != '0) done_twice++;
            end
            if (bus.timeout_err) err_seen++;
            prev_ready = bus.req_ready;
            prev_done  = bus.req_done;
        end
    end

    task automatic clear_log();
        g_id.delete(); g_data.delete(); g_cyc.delete();
        d_id.delete(); d_cyc.delete(); d_data.delete(); d_err.delete();
        d_start.delete(); d_arb.delete(); d_txb.delete(); d_txd.delete();
    endtask

    task automatic wait_ready(input int n, input string tag);
        int k = 0;
        while (g_id.size() < n && k < 1000) begin @(negedge clk); k++; end
        check(tag, g_id.size(), n);
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (d_id.size() < n && k < 1000) begin @(negedge clk); k++; end
        check(tag, d_id.size(), n);
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (!bus.tx_busy && k < 100) begin @(negedge clk); k++; end
        check(tag, bus.tx_busy, 1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        clear_log();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_arb_busy", bus.arb_busy, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_req_done", bus.req_done, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        rst_n = 1'b1;

        // Test 1: single request from requester 2, slow transmitter start
        start_lat = 3;
        @(negedge clk);
        bus.req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("t1_ready", bus.req_ready, 4'b0100);
        check("t1_tx_data", bus.tx_data, 8'hA5);
        check("t1_grant_id", bus.grant_id, 2);
        check("t1_tx_start", bus.tx_start, 1);
        check("t1_arb_busy", bus.arb_busy, 1);
        bus.req_valid = '0;
        @(negedge clk);
        check("t1_ready_one_cycle", bus.req_ready, 0);
        @(negedge clk);
        check("t1_start_held", bus.tx_start, 1);
        check("t1_busy_not_yet", bus.tx_busy, 0);
        wait_done(1, "t1_done_count");
        check("t1_done_id", d_id[0], 2);
        check("t1_done_data_stable", d_data[0], 8'hA5);
        check("t1_done_tx_idle", d_txb[0] + d_txd[0], 0);
        check("t1_start_low", d_start[0], 0);
        start_lat = 0;
        @(negedge clk);
        check("t1_idle_after", bus.arb_busy, 0);

        // Test 3: rr_ptr = 3 with requesters 3 and 0 valid
        clear_log();
        bus.req_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        bus.req_valid = 4'b1001;
        wait_ready(3, "t3_ready_count");
        bus.req_valid = '0;
        wait_done(3, "t3_done_count");
        check("t3_grant0", g_id[0], 3);
        check("t3_grant1", g_id[1], 0);
        check("t3_grant2", g_id[2], 3);
        check("t3_data1", g_data[1], 8'h00);
        check("t3_done0", d_id[0], 3);
        check("t3_done1", d_id[1], 0);

        // Test 4: requester 1 arrives while requester 0 is in flight
        @(negedge clk);
        clear_log();
        bus.req_data  = {8'h00, 8'h00, 8'h41, 8'h40};
        bus.req_valid = 4'b0001;
        wait_ready(1, "t4_ready0");
        bus.req_valid = '0;
        wait_busy("t4_busy");
        repeat (2) @(negedge clk);
        bus.req_valid = 4'b0010;
        wait_ready(2, "t4_ready1");
        bus.req_valid = '0;
        wait_done(2, "t4_done_count");
        check("t4_first_grant", g_id[0], 0);
        check("t4_second_grant", g_id[1], 1);
        check("t4_ready_after_done", g_cyc[1], d_cyc[0] + 1);
        check("t4_data1", g_data[1], 8'h41);

        // Test 5: reset asserted while in WAIT_DONE
        @(negedge clk);
        clear_log();
        bus.req_data  = {8'hC3, 8'h00, 8'h5C, 8'h00};
        bus.req_valid = 4'b0010;
        wait_ready(1, "t5_ready");
        check("t5_grant", g_id[0], 1);
        bus.req_valid = '0;
        wait_busy("t5_busy");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_async_arb_busy", bus.arb_busy, 0);
        check("t5_async_tx_start", bus.tx_start, 0);
        check("t5_async_tx_data", bus.tx_data, 0);
        check("t5_async_grant_id", bus.grant_id, 0);
        bus.req_valid = 4'b1010;
        repeat (3) @(negedge clk);
        check("t5_no_done", d_id.size(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_regrant_ready", bus.req_ready, 4'b0010);
        check("t5_regrant_data", bus.tx_data, 8'h5C);
        bus.req_valid = '0;
        wait_done(1, "t5_done_count");
        check("t5_done_id", d_id[0], 1);

        // Test 2: all requesters continuously valid
        do_reset();
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_valid = 4'b1111;
        wait_ready(5, "t2_ready_count");
        bus.req_valid = '0;
        wait_done(5, "t2_done_count");
        check("t2_data0", g_data[0], 8'h10);
        check("t2_data1", g_data[1], 8'h11);
        check("t2_data2", g_data[2], 8'h12);
        check("t2_data3", g_data[3], 8'h13);
        check("t2_data4", g_data[4], 8'h10);
        check("t2_done4", d_id[4], 0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Test 6: transmitter never goes busy, watchdog fires
        model_en = 1'b0;
        do_reset();
        bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h77};
        bus.req_valid = 4'b0001;
        wait_ready(1, "t6_ready");
        bus.req_valid = '0;
        @(negedge clk);
        check("t6_start_held", bus.tx_start, 1);
        wait_done(1, "t6_done_count");
        check("t6_latency", d_cyc[0] - g_cyc[0], 64);
        check("t6_timeout_err", d_err[0], 1);
        check("t6_tx_start_low", d_start[0], 0);
        check("t6_idle", d_arb[0], 0);
        check("t6_done_id", d_id[0], 0);
        @(negedge clk);
        check("t6_err_one_cycle", bus.timeout_err, 0);
`else
        check("no_timeout_err", err_seen, 0);
`endif

        check("ready_single_cycle", ready_twice, 0);
        check("done_single_cycle", done_twice, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end
endmodule
